// File: rtl/bomb_if.sv
// Bomb scheduler bus: player drop requests and positions in, bomb state out.
//   master: player/position side, drives requests and positions, observes bomb state.
//   slave : scheduler side, samples requests and positions, drives bomb state.
//   red/blue_drop_req  level drop requests
//   red/blue_pos_x/y   player grid positions (POS_W)
//   bomb_pos_x/y       latched bomb position
//   bomb_owner         0 = red, 1 = blue
//   bomb_armed         fuse running
//   bomb_enable        blast active
//   red/blue_grant     one-cycle acceptance pulses
//   red/blue_ready     player cooldown expired
interface bomb_if #(
  parameter int unsigned POS_W = 6
);
  logic             red_drop_req;
  logic             blue_drop_req;
  logic [POS_W-1:0] red_pos_x;
  logic [POS_W-1:0] red_pos_y;
  logic [POS_W-1:0] blue_pos_x;
  logic [POS_W-1:0] blue_pos_y;
  logic [POS_W-1:0] bomb_pos_x;
  logic [POS_W-1:0] bomb_pos_y;
  logic             bomb_owner;
  logic             bomb_armed;
  logic             bomb_enable;
  logic             red_grant;
  logic             blue_grant;
  logic             red_ready;
  logic             blue_ready;

  modport master (
    output red_drop_req, blue_drop_req,
    output red_pos_x, red_pos_y, blue_pos_x, blue_pos_y,
    input  bomb_pos_x, bomb_pos_y, bomb_owner, bomb_armed, bomb_enable,
    input  red_grant, blue_grant, red_ready, blue_ready
  );

  modport slave (
    input  red_drop_req, blue_drop_req,
    input  red_pos_x, red_pos_y, blue_pos_x, blue_pos_y,
    output bomb_pos_x, bomb_pos_y, bomb_owner, bomb_armed, bomb_enable,
    output red_grant, blue_grant, red_ready, blue_ready
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Shared bomb slot scheduler: arbitrates red/blue drop requests (round-robin
// on ties), latches the bomb position, sequences fuse -> blast -> idle and
// enforces a per-player cooldown after every grant.
// Ports:
//   i_clk    rising-edge clock
//   i_reset  synchronous active-high reset
//   bus      bomb_if.slave (requests/positions in, bomb state/grants/ready out)
// Optional feature macro: BOMB_REMOTE_DET_EN -- a rising edge of the owner's
// request while armed detonates the bomb early.
module bomb_scheduler #(
  parameter int unsigned POS_W           = 6,
  parameter int unsigned CNT_W           = 28,
  parameter int unsigned FUSE_CYCLES     = 150000000,
  parameter int unsigned BLAST_CYCLES    = 25000000,
  parameter int unsigned COOLDOWN_CYCLES = 250000000
) (
  input  logic  i_clk,
  input  logic  i_reset,
  bomb_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_BLAST = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LOAD    = CNT_W'(COOLDOWN_CYCLES);

  state_t           r_state,       w_state_nxt;
  logic [CNT_W-1:0] r_phase_cnt,   w_phase_cnt_nxt;
  logic [CNT_W-1:0] r_red_cd,      w_red_cd_nxt;
  logic [CNT_W-1:0] r_blue_cd,     w_blue_cd_nxt;
  logic             r_last_winner, w_last_winner_nxt;
  logic [POS_W-1:0] r_pos_x,       w_pos_x_nxt;
  logic [POS_W-1:0] r_pos_y,       w_pos_y_nxt;
  logic             r_owner,       w_owner_nxt;
  logic             r_armed,       w_armed_nxt;
  logic             r_enable,      w_enable_nxt;
  logic             r_red_grant,   w_red_grant_nxt;
  logic             r_blue_grant,  w_blue_grant_nxt;
  logic             r_red_ready,   w_red_ready_nxt;
  logic             r_blue_ready,  w_blue_ready_nxt;

  logic w_red_elig;
  logic w_blue_elig;
  logic w_accept;
  logic w_winner;
  logic w_detonate;

`ifdef BOMB_REMOTE_DET_EN
  // Previous-cycle request samples, used to find the owner's rising edge.
  logic r_red_req_d;
  logic r_blue_req_d;
  logic w_owner_req;
  logic w_owner_req_d;
`endif

  // Eligibility, arbitration and early-detonation detect.
  always_comb begin
    w_red_elig  = bus.red_drop_req  && (r_red_cd  == '0) && (r_state == S_IDLE);
    w_blue_elig = bus.blue_drop_req && (r_blue_cd == '0) && (r_state == S_IDLE);
    w_accept    = w_red_elig || w_blue_elig;
    // Tie goes to whoever did not win last; otherwise the lone eligible player.
    w_winner    = (w_red_elig && w_blue_elig) ? ~r_last_winner : w_blue_elig;
`ifdef BOMB_REMOTE_DET_EN
    w_owner_req   = r_owner ? bus.blue_drop_req : bus.red_drop_req;
    w_owner_req_d = r_owner ? r_blue_req_d      : r_red_req_d;
    w_detonate    = w_owner_req && !w_owner_req_d;
`else
    w_detonate    = 1'b0;
`endif
  end

  // Next-state and registered-output values.
  always_comb begin
    w_state_nxt       = r_state;
    w_phase_cnt_nxt   = r_phase_cnt;
    w_last_winner_nxt = r_last_winner;
    w_pos_x_nxt       = r_pos_x;
    w_pos_y_nxt       = r_pos_y;
    w_owner_nxt       = r_owner;
    w_red_grant_nxt   = 1'b0;
    w_blue_grant_nxt  = 1'b0;
    // Cooldowns free-run down to zero regardless of FSM state.
    w_red_cd_nxt      = (r_red_cd  == '0) ? '0 : r_red_cd  - CNT_W'(1);
    w_blue_cd_nxt     = (r_blue_cd == '0) ? '0 : r_blue_cd - CNT_W'(1);

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt       = S_ARMED;
          w_phase_cnt_nxt   = FUSE_LOAD;
          w_last_winner_nxt = w_winner;
          w_owner_nxt       = w_winner;
          w_pos_x_nxt       = w_winner ? bus.blue_pos_x : bus.red_pos_x;
          w_pos_y_nxt       = w_winner ? bus.blue_pos_y : bus.red_pos_y;
          if (w_winner) begin
            w_blue_grant_nxt = 1'b1;
            w_blue_cd_nxt    = CD_LOAD;
          end else begin
            w_red_grant_nxt  = 1'b1;
            w_red_cd_nxt     = CD_LOAD;
          end
        end
      end
      S_ARMED: begin
        if (w_detonate || (r_phase_cnt == '0)) begin
          w_state_nxt     = S_BLAST;
          w_phase_cnt_nxt = BLAST_LOAD;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt - CNT_W'(1);
        end
      end
      S_BLAST: begin
        if (r_phase_cnt == '0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_phase_cnt_nxt = r_phase_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    w_armed_nxt      = (w_state_nxt == S_ARMED);
    w_enable_nxt     = (w_state_nxt == S_BLAST);
    w_red_ready_nxt  = (w_red_cd_nxt  == '0);
    w_blue_ready_nxt = (w_blue_cd_nxt == '0);
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state       <= S_IDLE;
      r_phase_cnt   <= '0;
      r_red_cd      <= '0;
      r_blue_cd     <= '0;
      r_last_winner <= 1'b1;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_owner       <= 1'b0;
      r_armed       <= 1'b0;
      r_enable      <= 1'b0;
      r_red_grant   <= 1'b0;
      r_blue_grant  <= 1'b0;
      r_red_ready   <= 1'b1;
      r_blue_ready  <= 1'b1;
    end else begin
      r_state       <= w_state_nxt;
      r_phase_cnt   <= w_phase_cnt_nxt;
      r_red_cd      <= w_red_cd_nxt;
      r_blue_cd     <= w_blue_cd_nxt;
      r_last_winner <= w_last_winner_nxt;
      r_pos_x       <= w_pos_x_nxt;
      r_pos_y       <= w_pos_y_nxt;
      r_owner       <= w_owner_nxt;
      r_armed       <= w_armed_nxt;
      r_enable      <= w_enable_nxt;
      r_red_grant   <= w_red_grant_nxt;
      r_blue_grant  <= w_blue_grant_nxt;
      r_red_ready   <= w_red_ready_nxt;
      r_blue_ready  <= w_blue_ready_nxt;
    end
  end

`ifdef BOMB_REMOTE_DET_EN
  // Request history for rising-edge detection.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_red_req_d  <= 1'b0;
      r_blue_req_d <= 1'b0;
    end else begin
      r_red_req_d  <= bus.red_drop_req;
      r_blue_req_d <= bus.blue_drop_req;
    end
  end
`endif

  assign bus.bomb_pos_x  = r_pos_x;
  assign bus.bomb_pos_y  = r_pos_y;
  assign bus.bomb_owner  = r_owner;
  assign bus.bomb_armed  = r_armed;
  assign bus.bomb_enable = r_enable;
  assign bus.red_grant   = r_red_grant;
  assign bus.blue_grant  = r_blue_grant;
  assign bus.red_ready   = r_red_ready;
  assign bus.blue_ready  = r_blue_ready;

endmodule
